pipe_split_mult: RTL and testbench

PIPE_SPLIT_MULT -- requirements
Module: pipe_split_mult

---
 rtl/split_mult_pkg.sv | 18 +
 rtl/exact_nr_mxn.sv | 22 ++
 rtl/pipe_split_mult.sv | 109 ++++++++++
 tb/tb_pipe_split_mult.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/split_mult_pkg.sv
// Shared constants and the stage record used by every pipeline register of pipe_split_mult.
// The record is sized for the widest legal operand so one type serves all parameterisations.
package split_mult_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LOW_W    = 4;
  localparam int MAX_WIDTH    = 32;
  localparam int STAGE_DATA_W = 4 * MAX_WIDTH;

  typedef struct packed {
    logic                    valid;
    logic                    approx;
    logic [STAGE_DATA_W-1:0] data;
  } stage_t;

  localparam stage_t STAGE_RESET = '{valid: 1'b0, approx: 1'b0, data: '0};

endpackage

// File: rtl/exact_nr_mxn.sv
// Exact unsigned M x N combinational multiplier built as a shift-and-add array.
module exact_nr_mxn #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic [M-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [M+N-1:0] z
);

  logic [M+N-1:0] x_ext;

  assign x_ext = {{N{1'b0}}, x};

  always_comb begin
    z = '0;
    for (int i = 0; i < N; i++) begin
      if (y[i]) z = z + (x_ext << i);
    end
  end

endmodule

// File: rtl/pipe_split_mult.sv
// Three-stage split-operand multiplier: S1 operands, S2 four sub-products, S3 recombined product.
// Optional approximate mode drops the low x low sub-product for the entry that carries it.
module pipe_split_mult
  import split_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LOW_W = DEF_LOW_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int HI_W   = WIDTH - LOW_W;
  localparam int SUM_W  = 2 * WIDTH + 1;
  localparam int LL_OFF = 0;
  localparam int HL_OFF = LL_OFF + 2 * LOW_W;
  localparam int LH_OFF = HL_OFF + WIDTH;
  localparam int HH_OFF = LH_OFF + WIDTH;

  stage_t s1_q, s2_q, s3_q;
  stage_t s1_d, s2_d, s3_d;
  logic   en1, en2, en3;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
  // a stage loads when it is empty or its occupant moves on, so ready ripples back from out_ready.
  assign en3      = !s3_q.valid || out_ready;
  assign en2      = !s2_q.valid || en3;
  assign en1      = !s1_q.valid || en2;
  assign in_ready = en1;

  always_comb begin
    s1_d                   = STAGE_RESET;
    s1_d.valid             = in_valid;
    s1_d.approx            = approx;
    s1_d.data[WIDTH +: WIDTH] = a;
    s1_d.data[0 +: WIDTH]     = b;
  end

  logic [HI_W-1:0]      ah, bh;
  logic [LOW_W-1:0]     al, bl;
  logic [2*HI_W-1:0]    hh;
  logic [WIDTH-1:0]     hl, lh;
  logic [2*LOW_W-1:0]   ll;

  assign ah = s1_q.data[WIDTH + LOW_W +: HI_W];
  assign al = s1_q.data[WIDTH +: LOW_W];
  assign bh = s1_q.data[LOW_W +: HI_W];
  assign bl = s1_q.data[0 +: LOW_W];

  exact_nr_mxn #(.M(HI_W),  .N(HI_W))  u_hh (.x(ah), .y(bh), .z(hh));
  exact_nr_mxn #(.M(HI_W),  .N(LOW_W)) u_hl (.x(ah), .y(bl), .z(hl));
  exact_nr_mxn #(.M(LOW_W), .N(HI_W))  u_lh (.x(al), .y(bh), .z(lh));
  exact_nr_mxn #(.M(LOW_W), .N(LOW_W)) u_ll (.x(al), .y(bl), .z(ll));

  always_comb begin
    s2_d                            = STAGE_RESET;
    s2_d.valid                      = s1_q.valid;
    s2_d.approx                     = s1_q.approx;
    s2_d.data[LL_OFF +: 2*LOW_W]    = ll;
    s2_d.data[HL_OFF +: WIDTH]      = hl;
    s2_d.data[LH_OFF +: WIDTH]      = lh;
    s2_d.data[HH_OFF +: 2*HI_W]     = hh;
  end

  logic [SUM_W-1:0] hh_x, mid_x, ll_x, sum;

  // One spare bit keeps the intermediate sum exact; it can never be set for a true product.
  assign hh_x  = SUM_W'(s2_q.data[HH_OFF +: 2*HI_W]) << (2 * LOW_W);
  assign mid_x = (SUM_W'(s2_q.data[HL_OFF +: WIDTH]) + SUM_W'(s2_q.data[LH_OFF +: WIDTH])) << LOW_W;
  assign ll_x  = s2_q.approx ? '0 : SUM_W'(s2_q.data[LL_OFF +: 2*LOW_W]);
  assign sum   = hh_x + mid_x + ll_x;

  always_comb begin
    s3_d                       = STAGE_RESET;
    s3_d.valid                 = s2_q.valid;
    s3_d.approx                = s2_q.approx;
    s3_d.data[0 +: 2*WIDTH]    = sum[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= STAGE_RESET;
      s2_q <= STAGE_RESET;
      s3_q <= STAGE_RESET;
    end else begin
      if (en1) s1_q <= s1_d;
      if (en2) s2_q <= s2_d;
      if (en3) s3_q <= s3_d;
    end
  end

  assign out_valid = s3_q.valid;
  assign p         = s3_q.data[0 +: 2*WIDTH];
  assign busy      = s1_q.valid || s2_q.valid || s3_q.valid;

  // The shared record is wider than this instance needs; the spare bits are never read.
  logic unused_bits;
  assign unused_bits = ^{s1_q, s2_q, s3_q, sum[SUM_W-1]};

endmodule

// File: tb/tb_pipe_split_mult.sv
// Directed bench for pipe_split_mult: latency, approximate mode, streaming, stalls,
// mid-flight reset, and a small randomised sweep over three other operand splits.
module tb_pipe_split_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, approx, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        w1_iv, w1_ir, w1_ap, w1_ov, w1_or, w1_busy;
  logic [3:0]  w1_a, w1_b;
  logic [7:0]  w1_p;
  logic        w2_iv, w2_ir, w2_ap, w2_ov, w2_or, w2_busy;
  logic [3:0]  w2_a, w2_b;
  logic [7:0]  w2_p;
  logic        w3_iv, w3_ir, w3_ap, w3_ov, w3_or, w3_busy;
  logic [15:0] w3_a, w3_b;
  logic [31:0] w3_p;

  pipe_split_mult #(.WIDTH(8), .LOW_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .approx(approx), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy));

  pipe_split_mult #(.WIDTH(4), .LOW_W(1)) dut_w4l1 (
    .clk(clk), .rst(rst), .in_valid(w1_iv), .in_ready(w1_ir), .a(w1_a), .b(w1_b),
    .approx(w1_ap), .out_valid(w1_ov), .out_ready(w1_or), .p(w1_p), .busy(w1_busy));

  pipe_split_mult #(.WIDTH(4), .LOW_W(3)) dut_w4l3 (
    .clk(clk), .rst(rst), .in_valid(w2_iv), .in_ready(w2_ir), .a(w2_a), .b(w2_b),
    .approx(w2_ap), .out_valid(w2_ov), .out_ready(w2_or), .p(w2_p), .busy(w2_busy));

  pipe_split_mult #(.WIDTH(16), .LOW_W(8)) dut_w16l8 (
    .clk(clk), .rst(rst), .in_valid(w3_iv), .in_ready(w3_ir), .a(w3_a), .b(w3_b),
    .approx(w3_ap), .out_valid(w3_ov), .out_ready(w3_or), .p(w3_p), .busy(w3_busy));

  logic [15:0] exp_q[$];
  logic [7:0]  exp1_q[$];
  logic [7:0]  exp2_q[$];
  logic [31:0] exp3_q[$];

  int          checks = 0;
  int          errors = 0;
  logic        acc_now, del_now, ir_now, ov_now;
  logic [15:0] p_now;

  // Reference: full product, less the low x low term in approximate mode.
  function automatic logic [31:0] ref_mult(input logic [15:0] x, input logic [15:0] y,
                                           input logic ap, input int lw);
    logic [31:0] xx, yy, m;
    xx = {16'b0, x};
    yy = {16'b0, y};
    m  = (32'd1 << lw) - 32'd1;
    ref_mult = xx * yy - (ap ? (xx & m) * (yy & m) : 32'd0);
  endfunction

  // Drive one cycle on the main DUT and capture what the coming edge will do.
  task automatic step(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                      input logic ap, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = av;
    b         = bv;
    approx    = ap;
    out_ready = ordy;
    #1;
    acc_now = in_valid && in_ready;
    del_now = out_valid && out_ready;
    ir_now  = in_ready;
    ov_now  = out_valid;
    p_now   = p;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; approx = 1'b0; out_ready = 1'b0;
    w1_iv = 1'b0; w1_a = '0; w1_b = '0; w1_ap = 1'b0; w1_or = 1'b1;
    w2_iv = 1'b0; w2_a = '0; w2_b = '0; w2_ap = 1'b0; w2_or = 1'b1;
    w3_iv = 1'b0; w3_a = '0; w3_b = '0; w3_ap = 1'b0; w3_or = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (p !== 16'h0000) begin errors++; $display("FAIL reset_p: got %h want 0000", p); end
  endtask

  task automatic test_latency();
    int k;
    logic [15:0] pf;
    k = 0; pf = '0;
    step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (del_now && k == 0) begin k = i; pf = p_now; end
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL latency_cycles: got %0d want 3", k); end
    checks++; if (pf !== 16'hFE01) begin errors++; $display("FAIL latency_p_ff_ff: got %h want fe01", pf); end
  endtask

  task automatic test_approx();
    logic [15:0] got[3];
    int n;
    n = 0;
    step(1'b1, 8'h1F, 8'h1F, 1'b1, 1'b1);
    step(1'b1, 8'h1F, 8'h1F, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'hAB, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (del_now) begin
        if (n < 3) got[n] = p_now;
        n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL approx_count: got %0d want 3", n); end
    checks++; if (got[0] !== 16'd736) begin errors++; $display("FAIL approx_on: got %0d want 736", got[0]); end
    checks++; if (got[1] !== 16'd961) begin errors++; $display("FAIL approx_off: got %0d want 961", got[1]); end
    checks++; if (got[2] !== 16'd0) begin errors++; $display("FAIL zero_operand: got %0d want 0", got[2]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL approx_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got[10];
    int n, first, last;
    n = 0; first = -1; last = -1;
    for (int s = 0; s < 20; s++) begin
      if (s < 10) step(1'b1, 8'(s), 8'(s + 1), 1'b0, 1'b1);
      else        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (del_now) begin
        if (n < 10) got[n] = p_now;
        if (first < 0) first = s;
        last = s;
        n++;
      end
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL b2b_count: got %0d want 10", n); end
    checks++; if (last - first !== 9) begin errors++; $display("FAIL b2b_consecutive: got span %0d want 9", last - first); end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j] !== 16'(j * (j + 1))) begin
        errors++; $display("FAIL b2b_result_%0d: got %0d want %0d", j, got[j], j * (j + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int nxt;
    logic [15:0] ps[2];
    logic ir_last;
    logic [15:0] e;
    nxt = 0; ir_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'(nxt + 3), 8'(nxt + 7), 1'b0, 1'b0);
      if (acc_now) begin
        exp_q.push_back(16'(ref_mult(16'(nxt + 3), 16'(nxt + 7), 1'b0, 4)));
        nxt++;
      end
      if (c >= 3) ps[c - 3] = p_now;
      if (c == 4) ir_last = ir_now;
    end
    checks++; if (nxt !== 3) begin errors++; $display("FAIL stall_accepts: got %0d want 3", nxt); end
    checks++; if (ir_last !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", ir_last); end
    checks++; if (ov_now !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b want 1", ov_now); end
    checks++; if (ps[0] !== 16'd21 || ps[1] !== 16'd21) begin
      errors++; $display("FAIL stall_p_hold: got %0d then %0d want 21", ps[0], ps[1]);
    end
    for (int c = 0; c < 15; c++) begin
      step(nxt < 5, 8'(nxt + 3), 8'(nxt + 7), 1'b0, 1'b1);
      if (del_now) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL drain_unexpected: got %0d want none", p_now);
        end else begin
          e = exp_q.pop_front();
          if (p_now !== e) begin errors++; $display("FAIL drain_order: got %0d want %0d", p_now, e); end
        end
      end
      if (acc_now) begin
        exp_q.push_back(16'(ref_mult(16'(nxt + 3), 16'(nxt + 7), 1'b0, 4)));
        nxt++;
      end
    end
    checks++; if (exp_q.size() !== 0 || nxt !== 5) begin
      errors++; $display("FAIL drain_loss: got %0d left %0d sent want 0 left 5 sent", exp_q.size(), nxt);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_flight();
    int n, k;
    logic [15:0] pf;
    n = 0; k = 0; pf = '0;
    step(1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
    step(1'b1, 8'd4, 8'd5, 1'b0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_pre_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_rst_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flight_rst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; a = 8'd9; b = 8'd7; approx = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      if (del_now) begin
        if (n == 0) begin k = i; pf = p_now; end
        n++;
      end
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL flight_deliveries: got %0d want 1", n); end
    checks++; if (k !== 3) begin errors++; $display("FAIL flight_latency: got %0d want 3", k); end
    checks++; if (pf !== 16'd63) begin errors++; $display("FAIL flight_result: got %0d want 63", pf); end
  endtask

  task automatic test_sweep();
    logic [7:0]  e8;
    logic [31:0] e32;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      w1_iv = (cyc < 60) && ($urandom_range(0, 3) != 0);
      w2_iv = (cyc < 60) && ($urandom_range(0, 3) != 0);
      w3_iv = (cyc < 60) && ($urandom_range(0, 3) != 0);
      w1_or = (cyc >= 60) || ($urandom_range(0, 3) != 0);
      w2_or = (cyc >= 60) || ($urandom_range(0, 3) != 0);
      w3_or = (cyc >= 60) || ($urandom_range(0, 3) != 0);
      w1_a = (cyc == 0) ? 4'hF : 4'($urandom_range(0, 15));
      w1_b = (cyc == 0) ? 4'hF : 4'($urandom_range(0, 15));
      w2_a = (cyc == 0) ? 4'hF : 4'($urandom_range(0, 15));
      w2_b = (cyc == 0) ? 4'hF : 4'($urandom_range(0, 15));
      w3_a = (cyc == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      w3_b = (cyc == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      w1_ap = (cyc != 0) && ($urandom_range(0, 1) == 1);
      w2_ap = (cyc != 0) && ($urandom_range(0, 1) == 1);
      w3_ap = (cyc != 0) && ($urandom_range(0, 1) == 1);
      #1;
      if (w1_ov && w1_or) begin
        checks++;
        e8 = (exp1_q.size() != 0) ? exp1_q.pop_front() : 8'hxx;
        if (w1_p !== e8) begin errors++; $display("FAIL sweep_w4l1: got %0d want %0d", w1_p, e8); end
      end
      if (w2_ov && w2_or) begin
        checks++;
        e8 = (exp2_q.size() != 0) ? exp2_q.pop_front() : 8'hxx;
        if (w2_p !== e8) begin errors++; $display("FAIL sweep_w4l3: got %0d want %0d", w2_p, e8); end
      end
      if (w3_ov && w3_or) begin
        checks++;
        e32 = (exp3_q.size() != 0) ? exp3_q.pop_front() : 32'hxxxxxxxx;
        if (w3_p !== e32) begin errors++; $display("FAIL sweep_w16l8: got %0d want %0d", w3_p, e32); end
      end
      if (w1_iv && w1_ir) exp1_q.push_back(8'(ref_mult(16'(w1_a), 16'(w1_b), w1_ap, 1)));
      if (w2_iv && w2_ir) exp2_q.push_back(8'(ref_mult(16'(w2_a), 16'(w2_b), w2_ap, 3)));
      if (w3_iv && w3_ir) exp3_q.push_back(ref_mult(w3_a, w3_b, w3_ap, 8));
      @(posedge clk);
    end
    checks++; if (exp1_q.size() !== 0) begin errors++; $display("FAIL sweep_w4l1_left: got %0d want 0", exp1_q.size()); end
    checks++; if (exp2_q.size() !== 0) begin errors++; $display("FAIL sweep_w4l3_left: got %0d want 0", exp2_q.size()); end
    checks++; if (exp3_q.size() !== 0) begin errors++; $display("FAIL sweep_w16l8_left: got %0d want 0", exp3_q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_approx();
    test_back_to_back();
    test_backpressure();
    test_reset_flight();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
